// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
//   Shared definitions for the multiply/divide unit. The decoder uses the
//   same cal_op / wr_op encodings.
//
//   Contents:
//     cal_op_e    - calculation codes carried on cal_op[3:0]
//     wr_op_e     - direct HI/LO write codes carried on wr_op[3:0]
//     mdu_state_e - FSM state encoding of mdu_core
//     cal_op_valid(), cal_op_is_div() - decode helpers
//
//   Build option: MDU_MADD_EN. When defined, the madd/msub class codes
//   (5..8) are accepted. Otherwise they decode as undefined.
// ---------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [3:0] {
        CAL_NONE      = 4'd0,
        CAL_SIGN_MULT = 4'd1,
        CAL_ZERO_MULT = 4'd2,
        CAL_SIGN_DIV  = 4'd3,
        CAL_ZERO_DIV  = 4'd4,
        CAL_SIGN_MADD = 4'd5,
        CAL_ZERO_MADD = 4'd6,
        CAL_SIGN_MSUB = 4'd7,
        CAL_ZERO_MSUB = 4'd8
    } cal_op_e;

    typedef enum logic [3:0] {
        WR_NONE = 4'd0,
        WR_WHI  = 4'd1,
        WR_WLO  = 4'd2
    } wr_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // True for every code this build is able to execute.
    function automatic logic cal_op_valid(input logic [3:0] op);
        logic ok;
        ok = (op == CAL_SIGN_MULT) || (op == CAL_ZERO_MULT) ||
             (op == CAL_SIGN_DIV)  || (op == CAL_ZERO_DIV);
`ifdef MDU_MADD_EN
        ok = ok || (op == CAL_SIGN_MADD) || (op == CAL_ZERO_MADD) ||
                   (op == CAL_SIGN_MSUB) || (op == CAL_ZERO_MSUB);
`endif
        return ok;
    endfunction

    // Divides use the long latency; everything else uses the multiply latency.
    function automatic logic cal_op_is_div(input logic [3:0] op);
        return (op == CAL_SIGN_DIV) || (op == CAL_ZERO_DIV);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// ---------------------------------------------------------------------------
// mdu_arith
//   Purely combinational result generator. From the latched operands, the
//   latched op and the current HI/LO it produces the HI/LO value that
//   mdu_core commits when the busy count ends.
//
//   Ports:
//     op       in   4      latched calculation code (cal_op_e)
//     a, b     in   WIDTH  latched rs / rt operands
//     hi_cur   in   WIDTH  current HI (kept on divide by zero, madd base)
//     lo_cur   in   WIDTH  current LO
//     hi_next  out  WIDTH  HI value to commit
//     lo_next  out  WIDTH  LO value to commit
//
//   Build option: MDU_MADD_EN adds the {hi,lo} +/- product accumulate path.
// ---------------------------------------------------------------------------
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_cur,
    input  logic [WIDTH-1:0] lo_cur,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    localparam int W2 = 2 * WIDTH;

    logic             mul_signed;
    logic [W2-1:0]    a_ext;
    logic [W2-1:0]    b_ext;
    logic [W2-1:0]    prod;

    logic             div_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;

    always_comb begin
        // One 2W x 2W multiplier serves signed and unsigned forms: sign- or
        // zero-extending to 2W makes the low 2W bits the exact product.
        mul_signed = (op == CAL_SIGN_MULT) || (op == CAL_SIGN_MADD) ||
                     (op == CAL_SIGN_MSUB);
        a_ext = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod  = a_ext * b_ext;

        // Signed divide runs as an unsigned divide on magnitudes. The most
        // negative dividend by -1 falls out naturally: magnitude 2^(W-1)
        // divided by 1 wraps back to the most negative value, remainder 0.
        div_signed = (op == CAL_SIGN_DIV);
        a_neg   = div_signed & a[WIDTH-1];
        b_neg   = div_signed & b[WIDTH-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        // Keeps the divider input defined; the result is discarded for b==0.
        divisor = (b_mag == '0) ? WIDTH'(1) : b_mag;
        uq      = a_mag / divisor;
        ur      = a_mag % divisor;
        q       = (a_neg ^ b_neg) ? -uq : uq;
        r       = a_neg ? -ur : ur;

        hi_next = hi_cur;
        lo_next = lo_cur;
        case (op)
            CAL_SIGN_MULT, CAL_ZERO_MULT: begin
                {hi_next, lo_next} = prod;
            end
            CAL_SIGN_DIV, CAL_ZERO_DIV: begin
                // Divide by zero leaves HI/LO untouched.
                if (b != '0) begin
                    hi_next = r;
                    lo_next = q;
                end
            end
`ifdef MDU_MADD_EN
            CAL_SIGN_MADD, CAL_ZERO_MADD: begin
                {hi_next, lo_next} = {hi_cur, lo_cur} + prod;
            end
            CAL_SIGN_MSUB, CAL_ZERO_MSUB: begin
                {hi_next, lo_next} = {hi_cur, lo_cur} - prod;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_core.sv
// ---------------------------------------------------------------------------
// mdu_core
//   Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
//   A start launches the op on cal_op; busy then holds for MULT_CYCLES or
//   DIV_CYCLES cycles, after which HI/LO update atomically and done pulses.
//   HI/LO drive hi/lo directly for mfhi/mflo forwarding.
//
//   Ports:
//     clk     in   1      rising-edge clock
//     reset   in   1      synchronous, active-high reset
//     start   in   1      one-cycle launch strobe
//     cal_op  in   4      calculation code (mdu_pkg::cal_op_e)
//     wr_op   in   4      direct write code (mdu_pkg::wr_op_e), mthi/mtlo
//     a, b    in   WIDTH  rs / rt values
//     busy    out  1      registered, high while an op is running
//     done    out  1      one-cycle pulse in the first cycle HI/LO are new
//     hi, lo  out  WIDTH  HI / LO registers
//
//   Build option: MDU_MADD_EN enables the madd/msub codes (see mdu_pkg).
//
//   Handshake: start is accepted only in IDLE with a valid cal_op; busy is
//   the "not ready" indication and any start or wr_op seen while busy is
//   dropped. start has priority over wr_op in the same cycle, so wr_op is
//   acted on only in IDLE with start low.
// ---------------------------------------------------------------------------
module mdu_core
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       cal_op,
    input  logic [3:0]       wr_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e       state;
    mdu_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic             latch;
    logic             commit;
    logic             wr_hi;
    logic             wr_lo;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] arith_hi;
    logic [WIDTH-1:0] arith_lo;

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .hi_cur  (hi),
        .lo_cur  (lo),
        .hi_next (arith_hi),
        .lo_next (arith_lo)
    );

    // Next-state and control decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch      = 1'b0;
        commit     = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cal_op_valid(cal_op)) begin
                        latch      = 1'b1;
                        cnt_next   = cal_op_is_div(cal_op) ? CNT_W'(DIV_CYCLES)
                                                           : CNT_W'(MULT_CYCLES);
                        state_next = ST_RUN;
                    end
                end else begin
                    wr_hi = (wr_op == WR_WHI);
                    wr_lo = (wr_op == WR_WLO);
                end
            end
            ST_RUN: begin
                cnt_next = cnt - CNT_W'(1);
                // Count N..1 over N busy cycles; the edge leaving count 1
                // is the commit edge.
                if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= (state_next == ST_RUN);
            done  <= commit;

            if (latch) begin
                op_q <= cal_op;
                a_q  <= a;
                b_q  <= b;
            end

            // commit and the direct writes are mutually exclusive by state.
            if (commit) begin
                hi <= arith_hi;
                lo <= arith_lo;
            end else begin
                if (wr_hi) hi <= a;
                if (wr_lo) lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_mdu_core.sv
// ---------------------------------------------------------------------------
// tb_mdu_core
//   Self-checking bench for mdu_core (WIDTH=32, 5/10 cycle latencies).
//   A behavioural model computes HI/LO with 64-bit integer arithmetic and
//   tracks the commit edge of the pending op; a compare process checks
//   busy/done/hi/lo against it on every falling edge. Directed scenarios
//   pin the model with literal values, then randomized traffic follows.
//   Honours MDU_MADD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mdu_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cal_op = '0;
    logic [3:0]  wr_op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    mdu_core dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cal_op (cal_op),
        .wr_op  (wr_op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // ---------------- reference model ----------------
    function automatic bit model_valid(input int op);
`ifdef MDU_MADD_EN
        return (op >= 1) && (op <= 8);
`else
        return (op >= 1) && (op <= 4);
`endif
    endfunction

    function automatic logic [63:0] model_result(input int op, input logic [31:0] x,
                                                 input logic [31:0] y, input logic [31:0] h,
                                                 input logic [31:0] l);
        longint          sx, sy, q, r;
        longint unsigned ux, uy;
        logic [63:0]     base;
        logic [31:0]     uq32, ur32;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        base = {h, l};
        case (op)
            1: return sx * sy;
            2: return ux * uy;
            3: begin
                if (y == 0) return base;
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            4: begin
                if (y == 0) return base;
                uq32 = 32'(ux / uy);
                ur32 = 32'(ux % uy);
                return {ur32, uq32};
            end
            5: return base + 64'(sx * sy);
            6: return base + 64'(ux * uy);
            7: return base - 64'(sx * sy);
            8: return base - 64'(ux * uy);
            default: return base;
        endcase
    endfunction

    logic [31:0] m_hi = '0, m_lo = '0;
    bit          m_pend = 1'b0, m_done = 1'b0;
    int          m_edge = 0, m_commit_at = 0, m_op = 0;
    logic [31:0] m_a = '0, m_b = '0;

    always @(posedge clk) begin
        m_edge++;
        m_done = 1'b0;
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
            m_pend = 1'b0;
        end else if (m_pend) begin
            if (m_edge == m_commit_at) begin
                {m_hi, m_lo} = model_result(m_op, m_a, m_b, m_hi, m_lo);
                m_pend = 1'b0;
                m_done = 1'b1;
            end
        end else if (start) begin
            if (model_valid(int'(cal_op))) begin
                m_pend = 1'b1;
                m_op = int'(cal_op);
                m_a = a;
                m_b = b;
                m_commit_at = m_edge + ((m_op == 3 || m_op == 4) ? 10 : 5);
            end
        end else if (wr_op == 4'd1) begin
            m_hi = a;
        end else if (wr_op == 4'd2) begin
            m_lo = a;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("busy", 32'(busy), 32'(m_pend));
            check_eq("done", 32'(done), 32'(m_done));
            check_eq("hi", hi, m_hi);
            check_eq("lo", lo, m_lo);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic st, input logic [3:0] op, input logic [3:0] wr,
                        input logic [31:0] av, input logic [31:0] bv, input logic rs);
        start = st; cal_op = op; wr_op = wr; a = av; b = bv; reset = rs;
        @(posedge clk);
        #1;
        start = 1'b0; cal_op = '0; wr_op = '0; reset = 1'b0;
    endtask

    // Idle cycles scramble a/b to show operands are captured at start.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, $urandom, $urandom, 1'b0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            idle(1);
            n++;
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done_within_40", name);
        end
        idle(1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    int b0, d0;

    initial begin
        step(1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1);
        chk_en = 1'b1;

        // Reset state
        check_eq("reset_hi", hi, 32'h0);
        check_eq("reset_lo", lo, 32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);

        // Unsigned multiply 0xFFFFFFFF * 2
        b0 = busy_cnt; d0 = done_cnt;
        step(1'b1, 4'd2, 4'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_done("multu");
        check_eq("multu_hi", hi, 32'h0000_0001);
        check_eq("multu_lo", lo, 32'hFFFF_FFFE);
        check_eq("multu_busy_cycles", 32'(busy_cnt - b0), 32'd5);
        check_eq("multu_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Signed divide -7 / 2
        b0 = busy_cnt;
        step(1'b1, 4'd3, 4'd0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done("div_neg");
        check_eq("div_neg_lo", lo, 32'hFFFF_FFFD);
        check_eq("div_neg_hi", hi, 32'hFFFF_FFFF);
        check_eq("div_busy_cycles", 32'(busy_cnt - b0), 32'd10);

        // Divide by zero keeps HI/LO
        step(1'b0, 4'd0, 4'd1, 32'h1234, 32'h0, 1'b0);
        step(1'b0, 4'd0, 4'd2, 32'h5678, 32'h0, 1'b0);
        b0 = busy_cnt; d0 = done_cnt;
        step(1'b1, 4'd3, 4'd0, 32'h0000_0064, 32'h0, 1'b0);
        wait_done("div0");
        check_eq("div0_hi", hi, 32'h1234);
        check_eq("div0_lo", lo, 32'h5678);
        check_eq("div0_busy_cycles", 32'(busy_cnt - b0), 32'd10);
        check_eq("div0_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Most negative / -1
        step(1'b1, 4'd3, 4'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done("div_ovf");
        check_eq("div_ovf_lo", lo, 32'h8000_0000);
        check_eq("div_ovf_hi", hi, 32'h0);

        // Writes and a second start during busy are dropped
        b0 = busy_cnt; d0 = done_cnt;
        step(1'b1, 4'd2, 4'd0, 32'd3, 32'd5, 1'b0);
        idle(1);
        step(1'b0, 4'd0, 4'd1, 32'hDEAD_BEEF, 32'h0, 1'b0);
        step(1'b1, 4'd3, 4'd0, 32'd100, 32'd7, 1'b0);
        wait_done("blocked");
        idle(12);
        check_eq("blocked_hi", hi, 32'h0);
        check_eq("blocked_lo", lo, 32'd15);
        check_eq("blocked_busy_cycles", 32'(busy_cnt - b0), 32'd5);
        check_eq("blocked_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Reset three cycles after start
        step(1'b0, 4'd0, 4'd1, 32'hAAAA, 32'h0, 1'b0);
        step(1'b0, 4'd0, 4'd2, 32'hBBBB, 32'h0, 1'b0);
        d0 = done_cnt;
        step(1'b1, 4'd1, 4'd0, 32'd7, 32'd9, 1'b0);
        idle(2);
        step(1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b1);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_hi", hi, 32'h0);
        check_eq("rst_lo", lo, 32'h0);
        idle(12);
        check_eq("rst_no_done", 32'(done_cnt - d0), 32'd0);

        // SIGN_MADD 1*1 onto {0, 0xFFFFFFFF}
        step(1'b0, 4'd0, 4'd1, 32'h0, 32'h0, 1'b0);
        step(1'b0, 4'd0, 4'd2, 32'hFFFF_FFFF, 32'h0, 1'b0);
        b0 = busy_cnt;
        step(1'b1, 4'd5, 4'd0, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        wait_done("madd");
        check_eq("madd_hi", hi, 32'h1);
        check_eq("madd_lo", lo, 32'h0);
`else
        idle(8);
        check_eq("madd_off_busy_cycles", 32'(busy_cnt - b0), 32'd0);
        check_eq("madd_off_hi", hi, 32'h0);
        check_eq("madd_off_lo", lo, 32'hFFFF_FFFF);
`endif

        // Randomized traffic, including overlapping starts/writes and resets
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 99) < 30,
                 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 3)),
                 pick(), pick(),
                 $urandom_range(0, 199) == 0);
        end
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
